// File: rtl/score_text_pkg.sv
// Shared constants for the text-mode scoreboard: ASCII codes, packet fields,
// scan FSM states and the fixed text rows.
package score_text_pkg;

  localparam logic [6:0] SPACE = 7'h20;
  localparam logic [6:0] COLON = 7'h3A;
  localparam logic [6:0] STAR  = 7'h2A;
  localparam logic [6:0] QMARK = 7'h3F;
  localparam logic [6:0] GT    = 7'h3E;
  localparam logic [6:0] LT    = 7'h3C;
  localparam logic [6:0] NUM0  = 7'h30;
  localparam logic [6:0] EXCL  = 7'h21;

  localparam int ID_LSB  = 0;
  localparam int ID_MSB  = 7;
  localparam int DIG_LSB = 8;

  typedef enum logic {IDLE, SCAN} scan_state_t;

  // Fixed text, one byte per column, column 0 in the top byte
  localparam logic [127:0] HEADER_STR = ">>>>>SCORE:<<<<<";
  localparam logic [127:0] PLAYER_STR = "Player          ";
  localparam logic [127:0] YOU_STR    = "You are Player  ";

  function automatic logic [6:0] str_char(logic [127:0] s, logic [3:0] col);
    return s[8*(15-int'(col)) +: 7];
  endfunction

  function automatic logic [6:0] digit_char(logic [3:0] d);
    return (d > 4'd9) ? QMARK : NUM0 + 7'(d);
  endfunction

endpackage

// File: rtl/score_leader_scan.sv
// Sequential leader search over the score table: one BCD compare per cycle,
// ties keep the lower player ID, any restart pulse begins the scan again.
module score_leader_scan
  import score_text_pkg::*;
#(
  parameter int NUM_PLAYERS = 3,
  parameter int DIGITS      = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PLAYERS*4*DIGITS-1:0] table_flat,
  input  logic                          restart,
  output logic [7:0]                    leader_id,
  output logic                          leader_valid
);

  localparam int W = 4*DIGITS;

  scan_state_t  state;
  logic [3:0]   idx;
  logic [3:0]   cand;
  logic [W-1:0] idx_score;
  logic [W-1:0] cand_score;

  // The candidate is held as an index so the compare always sees the live table.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    idx_score  = '0;
    cand_score = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (idx == 4'(p+1))  idx_score  = table_flat[p*W +: W];
      if (cand == 4'(p+1)) cand_score = table_flat[p*W +: W];
    end
  end

  // Packed BCD orders the same as plain binary, so '>' is the magnitude compare.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= 4'd2;
      cand         <= 4'd1;
      leader_id    <= '0;
      leader_valid <= 1'b0;
    end else if (restart) begin
      state        <= SCAN;
      idx          <= 4'd2;
      cand         <= 4'd1;
      leader_valid <= 1'b0;
    end else if (state == SCAN) begin
      if (idx > 4'(NUM_PLAYERS)) begin
        leader_id    <= 8'(cand);
        leader_valid <= 1'b1;
        state        <= IDLE;
      end else begin
        if (idx_score > cand_score) cand <= idx;
        idx <= idx + 4'd1;
      end
    end
  end

endmodule

// File: rtl/score_text_rom.sv
// Scoreboard text source: score table with write arbitration, leader scan and
// a registered 16x16 character map. Define SCORE_LZB_EN for leading-zero blanking.
module score_text_rom
  import score_text_pkg::*;
#(
  parameter int NUM_PLAYERS = 3,
  parameter int DIGITS      = 6,
  parameter int NUM_EXT     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            char_xy,
  input  logic [7:0]            board_id,
  input  logic [4*DIGITS-1:0]   local_points,
  input  logic                  local_valid,
  input  logic [32*NUM_EXT-1:0] ext_data,
  input  logic [NUM_EXT-1:0]    ext_valid,
  output logic [6:0]            char_code,
  output logic [7:0]            leader_id,
  output logic                  leader_valid
);

  localparam int W = 4*DIGITS;

  logic [W-1:0]             table_q [NUM_PLAYERS];
  logic [W-1:0]             wr_data [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0]   wr_en;
  logic [NUM_PLAYERS*W-1:0] table_flat;

  // Later sources override earlier ones: local, then ext ports in ascending order.
  always_comb begin
    wr_en = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) wr_data[p] = table_q[p];
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (local_valid && board_id == 8'(p+1)) begin
        wr_en[p]   = 1'b1;
        wr_data[p] = local_points;
      end
      for (int e = 0; e < NUM_EXT; e++) begin
        if (ext_valid[e] && ext_data[32*e+ID_LSB +: ID_MSB-ID_LSB+1] == 8'(p+1)) begin
          wr_en[p]   = 1'b1;
          wr_data[p] = ext_data[32*e+DIG_LSB +: W];
        end
      end
    end
  end

  // NOTE: the table is a handful of registers, so it is reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PLAYERS; p++) table_q[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PLAYERS; p++)
        if (wr_en[p]) table_q[p] <= wr_data[p];
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) table_flat[p*W +: W] = table_q[p];
  end

  score_leader_scan #(
    .NUM_PLAYERS(NUM_PLAYERS),
    .DIGITS     (DIGITS)
  ) u_scan (
    .clk         (clk),
    .rst_n       (rst_n),
    .table_flat  (table_flat),
    .restart     (|wr_en),
    .leader_id   (leader_id),
    .leader_valid(leader_valid)
  );

  logic [3:0]   row;
  logic [3:0]   col;
  logic [W-1:0] row_score;
  logic [6:0]   next_code;
  int           k;

  assign row = char_xy[7:4];
  assign col = char_xy[3:0];

  always_comb begin
    next_code = SPACE;
    row_score = '0;
    for (int p = 0; p < NUM_PLAYERS; p++)
      if (row == 4'(p+1)) row_score = table_q[p];
    k = 15 - int'(col);
    if (row == 4'd0) begin
      next_code = str_char(HEADER_STR, col);
    end else if (int'(row) <= NUM_PLAYERS) begin
      if (col <= 4'd5)       next_code = str_char(PLAYER_STR, col);
      else if (col == 4'd6)  next_code = NUM0 + 7'(row);
      else if (col == 4'd7)  next_code = COLON;
      else if (col == 4'd8)  next_code = (leader_valid && leader_id == {4'd0, row}) ? STAR : SPACE;
      else if (k < DIGITS) begin
        next_code = digit_char(row_score[4*k +: 4]);
`ifdef SCORE_LZB_EN
        // Blank a digit when it and everything above it are zero; digit 0 always shows.
        if (k != 0 && (row_score >> (4*k)) == '0) next_code = SPACE;
`endif
      end
    end else if (int'(row) == NUM_PLAYERS + 2) begin
      if (col <= 4'd13)      next_code = str_char(YOU_STR, col);
      else if (col == 4'd14) next_code = (board_id > 8'd9) ? QMARK : NUM0 + 7'(board_id[3:0]);
      else                   next_code = EXCL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) char_code <= SPACE;
    else        char_code <= next_code;
  end

endmodule

// File: tb/tb_score_text_rom.sv
// Directed self-checking bench for score_text_rom with default parameters
// (3 players, 6 digits, 2 external ports).
module tb_score_text_rom;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  char_xy;
  logic [7:0]  board_id;
  logic [23:0] local_points;
  logic        local_valid;
  logic [63:0] ext_data;
  logic [1:0]  ext_valid;
  logic [6:0]  char_code;
  logic [7:0]  leader_id;
  logic        leader_valid;

  int tests = 0;
  int fails = 0;

  logic [23:0] scores [1:3];
  logic        exp_lv;
  int          exp_lid;

  score_text_rom dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .char_xy     (char_xy),
    .board_id    (board_id),
    .local_points(local_points),
    .local_valid (local_valid),
    .ext_data    (ext_data),
    .ext_valid   (ext_valid),
    .char_code   (char_code),
    .leader_id   (leader_id),
    .leader_valid(leader_valid)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_cell(int r, int c);
    byte        line [16];
    string      s;
    logic [3:0] d;
    logic       seen;
    for (int i = 0; i < 16; i++) line[i] = 8'h20;
    if (r == 0) begin
      s = ">>>>>SCORE:<<<<<";
      for (int i = 0; i < 16; i++) line[i] = s[i];
    end else if (r >= 1 && r <= 3) begin
      s = "Player";
      for (int i = 0; i < 6; i++) line[i] = s[i];
      line[6] = byte'(8'h30 + r);
      line[7] = ":";
      if (exp_lv && exp_lid == r) line[8] = "*";
      seen = 1'b0;
      for (int j = 5; j >= 0; j--) begin
        d = scores[r][4*j +: 4];
        if (d != 4'd0 || j == 0) seen = 1'b1;
        line[15-j] = (d > 4'd9) ? 8'h3F : byte'(8'h30 + d);
`ifdef SCORE_LZB_EN
        if (!seen) line[15-j] = 8'h20;
`endif
      end
    end else if (r == 5) begin
      s = "You are Player";
      for (int i = 0; i < 14; i++) line[i] = s[i];
      line[14] = (board_id > 8'd9) ? 8'h3F : byte'(8'h30 + board_id[3:0]);
      line[15] = "!";
    end
    return 7'(line[c]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cell(int r, int c);
    @(negedge clk);
    char_xy = {4'(r), 4'(c)};
    tick();
    check($sformatf("cell_%0d_%0d", r, c), 32'(char_code), 32'(exp_cell(r, c)));
  endtask

  task automatic check_rows(int r0, int r1);
    for (int r = r0; r <= r1; r++)
      for (int c = 0; c < 16; c++) check_cell(r, c);
  endtask

  // Drives one strobe cycle; returns 1 time unit after the write edge.
  task automatic do_write(logic lv, logic [23:0] lp, logic [1:0] ev, logic [63:0] ed);
    @(negedge clk);
    local_valid  = lv;
    local_points = lp;
    ext_valid    = ev;
    ext_data     = ed;
    tick();
    local_valid = 1'b0;
    ext_valid   = 2'b00;
  endtask

  task automatic check_leader(string tag, logic v, int id);
    check({tag, "_valid"}, 32'(leader_valid), 32'(v));
    if (v) check({tag, "_id"}, 32'(leader_id), 32'(id));
  endtask

  initial begin
    rst_n        = 1'b0;
    char_xy      = 8'h00;
    board_id     = 8'd2;
    local_points = '0;
    local_valid  = 1'b0;
    ext_data     = '0;
    ext_valid    = '0;
    for (int i = 1; i <= 3; i++) scores[i] = '0;
    exp_lv  = 1'b0;
    exp_lid = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_char", 32'(char_code), 32'h20);
    check("rst_lid", 32'(leader_id), 32'h0);
    check("rst_lv", 32'(leader_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_char", 32'(char_code), 32'h20);

    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) check_cell(r, c);

    // Local write to entry 2, leader after 3 cycles
    do_write(1'b1, 24'h000123, 2'b00, '0);
    scores[2] = 24'h000123;
    check_leader("w1_e0", 1'b0, 0);
    tick(); check_leader("w1_e1", 1'b0, 0);
    tick(); check_leader("w1_e2", 1'b0, 0);
    tick(); check_leader("w1_e3", 1'b1, 2);
    exp_lv = 1'b1; exp_lid = 2;
    check_rows(0, 5);

    // Same-cycle writes to entry 1: ext1 beats ext0 beats local
    board_id = 8'd1;
    do_write(1'b1, 24'h000050, 2'b11, {24'h000090, 8'd1, 24'h000070, 8'd1});
    scores[1] = 24'h000090;
    exp_lv = 1'b0;
    check_leader("prio_e0", 1'b0, 0);
    repeat (3) tick();
    check_leader("prio_e3", 1'b1, 2);
    exp_lv = 1'b1;
    check_rows(1, 5);

    // Out-of-range IDs (7, 0, 12) are all dropped, no scan starts
    board_id = 8'h0C;
    do_write(1'b1, 24'h777777, 2'b11, {24'h999999, 8'd0, 24'h999999, 8'd7});
    check_leader("bad_e0", 1'b1, 2);
    tick(); check_leader("bad_e1", 1'b1, 2);
    check_rows(1, 5);
    board_id = 8'd2;

    // New maximum in the last entry
    do_write(1'b0, '0, 2'b01, {32'h0, 24'h000600, 8'd3});
    scores[3] = 24'h000600;
    exp_lv = 1'b0;
    repeat (2) tick();
    check_leader("hi_e2", 1'b0, 0);
    tick(); check_leader("hi_e3", 1'b1, 3);
    exp_lv = 1'b1; exp_lid = 3;
    check_rows(1, 3);

    // Tie between entries 1 and 3, restarted by a write to entry 2
    do_write(1'b0, '0, 2'b11, {24'h000500, 8'd3, 24'h000500, 8'd1});
    check_leader("tie_a0", 1'b0, 0);
    do_write(1'b0, '0, 2'b01, {32'h0, 24'h000100, 8'd2});
    scores[1] = 24'h000500; scores[2] = 24'h000100; scores[3] = 24'h000500;
    exp_lv = 1'b0;
    check_leader("tie_b0", 1'b0, 0);
    tick(); check_leader("tie_b1", 1'b0, 0);
    tick(); check_leader("tie_b2", 1'b0, 0);
    tick(); check_leader("tie_b3", 1'b1, 1);
    exp_lv = 1'b1; exp_lid = 1;
    check_rows(1, 3);

    // Three different entries in one cycle; zero, small and non-BCD scores
    board_id = 8'd3;
    do_write(1'b1, 24'h0A0F05, 2'b11, {24'h000000, 8'd1, 24'h000042, 8'd2});
    scores[1] = 24'h000000; scores[2] = 24'h000042; scores[3] = 24'h0A0F05;
    exp_lv = 1'b0;
    repeat (3) tick();
    check_leader("multi_e3", 1'b1, 3);
    exp_lv = 1'b1; exp_lid = 3;
    check_rows(1, 5);

    // Asynchronous reset in the middle of a scan
    do_write(1'b0, '0, 2'b01, {32'h0, 24'h999999, 8'd1});
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_lv", 32'(leader_valid), 32'h0);
    check("mid_rst_lid", 32'(leader_id), 32'h0);
    check("mid_rst_char", 32'(char_code), 32'h20);
    for (int i = 1; i <= 3; i++) scores[i] = '0;
    exp_lv = 1'b0; exp_lid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    check_rows(1, 3);
    check("mid_rst_idle", 32'(leader_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
